// File: rtl/button_conditioner.sv
// Four-button front end: two-flop synchronisers, per-bit counter debounce,
// rising-edge press detection with lowest-index priority, and a 2-entry
// event FIFO popped by the consumer with ack.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] b_raw,
  input  logic       ack,
  output logic       valid,
  output logic [2:0] code,
  output logic [3:0] onehot,
  output logic       full,
  output logic       drop
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // Counter value seen on the cycle whose increment would reach the threshold.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    sync1, sync2;
  logic [3:0]    deb, deb_prev;
  logic [CW-1:0] cnt [4];

  logic [3:0]    press;
  logic          press_any;
  logic          press_multi;
  logic [1:0]    press_idx;

  logic [1:0]    mem [2];
  logic          rd_ptr, wr_ptr;
  logic [1:0]    count;
  logic          pop, push;

  // Two-flop synchroniser for the raw asynchronous buttons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= b_raw;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: count disagreeing cycles, toggle the level at threshold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb      <= '0;
      deb_prev <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      deb_prev <= deb;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i] <= '0;
          deb[i] <= ~deb[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press detection and lowest-index priority selection.
  always_comb begin
    press       = deb & ~deb_prev;
    press_any   = |press;
    press_multi = |(press & (press - 4'd1));
    press_idx   = 2'd0;
    for (int unsigned i = 4; i > 0; i--) begin
      if (press[i-1]) press_idx = 2'(i - 1);
    end
  end

  assign pop  = ack & valid;
  // A full FIFO still accepts a push when the head leaves at the same edge.
  assign push = press_any & (~full | pop);

  // FIFO pointers, contents, occupancy and the registered drop pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
      drop   <= 1'b0;
    end else begin
      drop <= press_multi | (press_any & ~push);
      if (push) begin
        mem[wr_ptr] <= press_idx;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Consumer-facing outputs decoded from registered FIFO state only.
  always_comb begin
    valid  = (count != 2'd0);
    full   = (count == 2'd2);
    code   = '0;
    onehot = '0;
    if (valid) begin
      code   = {1'b0, mem[rd_ptr]} + 3'd1;
      onehot = 4'd1 << mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed, table-driven bench for button_conditioner with DEBOUNCE_CYCLES=4.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] b_raw;
  logic       ack;
  logic       valid;
  logic [2:0] code;
  logic [3:0] onehot;
  logic       full;
  logic       drop;

  int n_checks = 0;
  int n_fail   = 0;

  button_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .b_raw  (b_raw),
    .ack    (ack),
    .valid  (valid),
    .code   (code),
    .onehot (onehot),
    .full   (full),
    .drop   (drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] b;
    logic       ack;
    int         n;      // edges to run with these inputs
    logic       every;  // compare after every edge, else only after the last
    logic       valid;
    logic [2:0] code;
    logic [3:0] onehot;
    logic       full;
    logic       drop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] b, logic a, int n, logic every,
                              logic v, logic [2:0] c, logic [3:0] oh,
                              logic f, logic d);
    vec_t r;
    r.b = b; r.ack = a; r.n = n; r.every = every;
    r.valid = v; r.code = c; r.onehot = oh; r.full = f; r.drop = d;
    return r;
  endfunction

  task automatic check(string name, logic [9:0] act, logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {valid,code,onehot,full,drop}=%b required %b",
               name, act, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {valid, code, onehot, full, drop};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; b_raw = '0; ack = 1'b0;

    // Clean press of button 2, ack, release.
    vecs.push_back(mk(4'b0010, 0, 6, 1, 0, 3'd0, 4'b0000, 0, 0));
    vecs.push_back(mk(4'b0010, 0, 1, 0, 1, 3'd2, 4'b0010, 0, 0));
    vecs.push_back(mk(4'b0010, 0, 5, 1, 1, 3'd2, 4'b0010, 0, 0));
    vecs.push_back(mk(4'b0010, 1, 1, 0, 0, 3'd0, 4'b0000, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 10, 1, 0, 3'd0, 4'b0000, 0, 0));
    // Glitch of three cycles on button 1.
    vecs.push_back(mk(4'b0001, 0, 3, 1, 0, 3'd0, 4'b0000, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 10, 1, 0, 3'd0, 4'b0000, 0, 0));
    // Simultaneous press of buttons 1 and 4.
    vecs.push_back(mk(4'b1001, 0, 6, 1, 0, 3'd0, 4'b0000, 0, 0));
    vecs.push_back(mk(4'b1001, 0, 1, 0, 1, 3'd1, 4'b0001, 0, 1));
    vecs.push_back(mk(4'b1001, 0, 4, 1, 1, 3'd1, 4'b0001, 0, 0));
    vecs.push_back(mk(4'b1001, 1, 1, 0, 0, 3'd0, 4'b0000, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 10, 1, 0, 3'd0, 4'b0000, 0, 0));
    // Overflow: 3, 2, 4 with no ack, then drain.
    vecs.push_back(mk(4'b0100, 0, 7, 0, 1, 3'd3, 4'b0100, 0, 0));
    vecs.push_back(mk(4'b0010, 0, 6, 1, 1, 3'd3, 4'b0100, 0, 0));
    vecs.push_back(mk(4'b0010, 0, 1, 0, 1, 3'd3, 4'b0100, 1, 0));
    vecs.push_back(mk(4'b1000, 0, 6, 1, 1, 3'd3, 4'b0100, 1, 0));
    vecs.push_back(mk(4'b1000, 0, 1, 0, 1, 3'd3, 4'b0100, 1, 1));
    vecs.push_back(mk(4'b1000, 0, 1, 0, 1, 3'd3, 4'b0100, 1, 0));
    vecs.push_back(mk(4'b0000, 1, 1, 0, 1, 3'd2, 4'b0010, 0, 0));
    vecs.push_back(mk(4'b0000, 1, 1, 0, 0, 3'd0, 4'b0000, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 10, 1, 0, 3'd0, 4'b0000, 0, 0));
    // Full FIFO {1,2}: ack coincides with the push of 4.
    vecs.push_back(mk(4'b0001, 0, 7, 0, 1, 3'd1, 4'b0001, 0, 0));
    vecs.push_back(mk(4'b0010, 0, 7, 0, 1, 3'd1, 4'b0001, 1, 0));
    vecs.push_back(mk(4'b1000, 0, 6, 1, 1, 3'd1, 4'b0001, 1, 0));
    vecs.push_back(mk(4'b1000, 1, 1, 0, 1, 3'd2, 4'b0010, 1, 0));
    vecs.push_back(mk(4'b1000, 1, 1, 0, 1, 3'd4, 4'b1000, 0, 0));
    vecs.push_back(mk(4'b1000, 1, 1, 0, 0, 3'd0, 4'b0000, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 10, 1, 0, 3'd0, 4'b0000, 0, 0));
    // One entry: push of 1 coincides with pop of 3.
    vecs.push_back(mk(4'b0100, 0, 7, 0, 1, 3'd3, 4'b0100, 0, 0));
    vecs.push_back(mk(4'b0001, 0, 6, 1, 1, 3'd3, 4'b0100, 0, 0));
    vecs.push_back(mk(4'b0001, 1, 1, 0, 1, 3'd1, 4'b0001, 0, 0));
    vecs.push_back(mk(4'b0001, 1, 1, 0, 0, 3'd0, 4'b0000, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 10, 1, 0, 3'd0, 4'b0000, 0, 0));

    // Reset state.
    tick(); tick();
    check("reset_state", outs(), 10'b0);
    rst = 1'b0;
    tick(); tick();
    check("idle_after_reset", outs(), 10'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      b_raw = vecs[i].b;
      ack   = vecs[i].ack;
      for (int k = 0; k < vecs[i].n; k++) begin
        tick();
        if (vecs[i].every || k == vecs[i].n - 1)
          check($sformatf("vec%0d_edge%0d", i, k + 1), outs(),
                {vecs[i].valid, vecs[i].code, vecs[i].onehot,
                 vecs[i].full, vecs[i].drop});
      end
    end
    ack = 1'b0;

    // Reset while an entry is pending, button 2 held through release.
    b_raw = 4'b0010;
    for (int k = 0; k < 7; k++) tick();
    check("pre_reset_valid", outs(), {1'b1, 3'd2, 4'b0010, 1'b0, 1'b0});
    #2 rst = 1'b1;
    #1 check("async_reset_clear", outs(), 10'b0);
    tick();
    check("reset_held", outs(), 10'b0);
    #2 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("post_reset_edge%0d", k + 1), outs(), 10'b0);
    end
    tick();
    check("post_reset_edge7", outs(), {1'b1, 3'd2, 4'b0010, 1'b0, 1'b0});
    tick();
    check("post_reset_single_event", outs(), {1'b1, 3'd2, 4'b0010, 1'b0, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
